// File: rtl/cp0_tlb_ctrl.sv
// CP0 TLB management registers and TLBR/TLBWI/TLBWR/TLBP sequencer.
// Define CP0_TLBWR_EN to implement Random/Wired; otherwise TLBWR behaves as TLBWI.
module cp0_tlb_ctrl #(
    parameter int unsigned TLB_NUM  = 32,
    parameter int unsigned IDX_BITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    input  logic [1:0]          op,
    output logic                op_ready,
    output logic                op_done,
    input  logic                mtc0_we,
    input  logic [4:0]          cp0_addr,
    input  logic [31:0]         mtc0_data,
    output logic [31:0]         mfc0_data,
    input  logic                exc_tlb,
    input  logic [18:0]         exc_badvpn2,
    output logic                tlb_we,
    output logic [IDX_BITS-1:0] tlb_index,
    output logic [11:0]         tlb_mask,
    output logic [31:0]         tlb_entryhi,
    output logic [31:0]         tlb_entrylo0,
    output logic [31:0]         tlb_entrylo1,
    input  logic [11:0]         tlb_mask_rd,
    input  logic [31:0]         tlb_entryhi_rd,
    input  logic [31:0]         tlb_entrylo0_rd,
    input  logic [31:0]         tlb_entrylo1_rd,
    input  logic [31:0]         tlb_probe_idx
);

    localparam logic [IDX_BITS-1:0] IDX_MAX = IDX_BITS'(TLB_NUM - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
    typedef enum logic [1:0] {OP_TLBR, OP_TLBWI, OP_TLBWR, OP_TLBP} op_t;

    state_t state, state_next;
    op_t    op_q;

    logic                index_p;
    logic [IDX_BITS-1:0] index_f, index_q, exec_index;
    logic [25:0]         lo0, lo1;
    logic [11:0]         pmask;
    logic [18:0]         vpn2;
    logic [7:0]          asid;
    logic [IDX_BITS-1:0] random, wired;

    logic accept, cap_read, cap_probe;
    logic we_index, we_lo0, we_lo1, we_pmask, we_hi;
    logic unused_bits;

    assign we_index = mtc0_we && (cp0_addr == 5'd0);
    assign we_lo0   = mtc0_we && (cp0_addr == 5'd2);
    assign we_lo1   = mtc0_we && (cp0_addr == 5'd3);
    assign we_pmask = mtc0_we && (cp0_addr == 5'd5);
    assign we_hi    = mtc0_we && (cp0_addr == 5'd10);

    assign accept    = op_valid && op_ready;
    assign cap_read  = (state == S_EXEC) && (op_q == OP_TLBR);
    assign cap_probe = (state == S_EXEC) && (op_q == OP_TLBP);

    assign unused_bits = ^{mtc0_data[12:8], tlb_entryhi_rd[12:8], tlb_entrylo0_rd[31:26],
                           tlb_entrylo1_rd[31:26], tlb_probe_idx[30:IDX_BITS]};

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        op_ready   = 1'b0;
        op_done    = 1'b0;
        tlb_we     = 1'b0;
        tlb_index  = index_f;
        case (state)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) state_next = S_EXEC;
            end
            S_EXEC: begin
                tlb_we     = (op_q == OP_TLBWI) || (op_q == OP_TLBWR);
                tlb_index  = exec_index;
                state_next = S_DONE;
            end
            S_DONE: begin
                op_done    = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operands are frozen at accept so an mtc0 in the same cycle cannot leak in.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= OP_TLBR;
            index_q <= '0;
        end else if (accept) begin
            op_q    <= op_t'(op);
            index_q <= index_f;
        end
    end

`ifdef CP0_TLBWR_EN
    logic [IDX_BITS-1:0] random_next, rand_q;
    logic                we_wired;

    assign we_wired = mtc0_we && (cp0_addr == 5'd6);

    always_comb begin
        if (wired >= IDX_MAX)
            random_next = IDX_MAX;
        else if ((wired == '0) ? (random == '0) : (random <= wired + IDX_BITS'(1)))
            random_next = IDX_MAX;
        else
            random_next = random - IDX_BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            random <= IDX_MAX;
            wired  <= '0;
        end else if (we_wired) begin
            wired  <= mtc0_data[IDX_BITS-1:0];
            random <= IDX_MAX;
        end else begin
            random <= random_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)         rand_q <= IDX_MAX;
        else if (accept) rand_q <= random;
    end

    assign exec_index = (op_q == OP_TLBWR) ? rand_q : index_q;
`else
    assign random     = '0;
    assign wired      = '0;
    assign exec_index = index_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            index_p <= 1'b0;
            index_f <= '0;
        end else if (cap_probe) begin
            index_p <= tlb_probe_idx[31];
            index_f <= tlb_probe_idx[IDX_BITS-1:0];
        end else if (we_index) begin
            index_f <= mtc0_data[IDX_BITS-1:0];
        end
    end

    // Priority per register: EXEC capture, then exception, then mtc0.
    always_ff @(posedge clk) begin
        if (rst) begin
            vpn2 <= '0;
            asid <= '0;
        end else if (cap_read) begin
            vpn2 <= tlb_entryhi_rd[31:13];
            asid <= tlb_entryhi_rd[7:0];
        end else if (exc_tlb) begin
            vpn2 <= exc_badvpn2;
        end else if (we_hi) begin
            vpn2 <= mtc0_data[31:13];
            asid <= mtc0_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lo0   <= '0;
            lo1   <= '0;
            pmask <= '0;
        end else if (cap_read) begin
            lo0   <= tlb_entrylo0_rd[25:0];
            lo1   <= tlb_entrylo1_rd[25:0];
            pmask <= tlb_mask_rd;
        end else begin
            if (we_lo0)   lo0   <= mtc0_data[25:0];
            if (we_lo1)   lo1   <= mtc0_data[25:0];
            if (we_pmask) pmask <= mtc0_data[24:13];
        end
    end

    assign tlb_entryhi  = {vpn2, 5'b0, asid};
    assign tlb_entrylo0 = {6'b0, lo0};
    assign tlb_entrylo1 = {6'b0, lo1};
    assign tlb_mask     = pmask;

    always_comb begin
        mfc0_data = '0;
        case (cp0_addr)
            5'd0:    mfc0_data = {index_p, {(31 - IDX_BITS){1'b0}}, index_f};
            5'd1:    mfc0_data = {{(32 - IDX_BITS){1'b0}}, random};
            5'd2:    mfc0_data = tlb_entrylo0;
            5'd3:    mfc0_data = tlb_entrylo1;
            5'd5:    mfc0_data = {7'b0, pmask, 13'b0};
            5'd6:    mfc0_data = {{(32 - IDX_BITS){1'b0}}, wired};
            5'd10:   mfc0_data = tlb_entryhi;
            default: mfc0_data = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_tlb_ctrl.sv
// Randomized bench for cp0_tlb_ctrl against a cycle-level register model.
// Follows CP0_TLBWR_EN the same way the design does.
module tb_cp0_tlb_ctrl;

    logic        clk = 1'b0;
    logic        rst, op_valid, mtc0_we, exc_tlb;
    logic [1:0]  op;
    logic [4:0]  cp0_addr;
    logic [31:0] mtc0_data, mfc0_data;
    logic [18:0] exc_badvpn2;
    logic        op_ready, op_done, tlb_we;
    logic [4:0]  tlb_index;
    logic [11:0] tlb_mask, tlb_mask_rd;
    logic [31:0] tlb_entryhi, tlb_entrylo0, tlb_entrylo1;
    logic [31:0] tlb_entryhi_rd, tlb_entrylo0_rd, tlb_entrylo1_rd, tlb_probe_idx;

    always #5 clk = ~clk;

`ifdef CP0_TLBWR_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    cp0_tlb_ctrl #(.TLB_NUM(32), .IDX_BITS(5)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .op_ready(op_ready),
        .op_done(op_done), .mtc0_we(mtc0_we), .cp0_addr(cp0_addr), .mtc0_data(mtc0_data),
        .mfc0_data(mfc0_data), .exc_tlb(exc_tlb), .exc_badvpn2(exc_badvpn2),
        .tlb_we(tlb_we), .tlb_index(tlb_index), .tlb_mask(tlb_mask),
        .tlb_entryhi(tlb_entryhi), .tlb_entrylo0(tlb_entrylo0), .tlb_entrylo1(tlb_entrylo1),
        .tlb_mask_rd(tlb_mask_rd), .tlb_entryhi_rd(tlb_entryhi_rd),
        .tlb_entrylo0_rd(tlb_entrylo0_rd), .tlb_entrylo1_rd(tlb_entrylo1_rd),
        .tlb_probe_idx(tlb_probe_idx)
    );

    int checks = 0;
    int errors = 0;

    // Model: architectural register values plus cycles elapsed since accept.
    logic [31:0] m_index, m_lo0, m_lo1, m_pm, m_hi;
    int          m_random, m_wired, m_phase, m_op, m_idx_lat, m_rnd_lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_index = 0; m_lo0 = 0; m_lo1 = 0; m_pm = 0; m_hi = 0;
        m_random = 31; m_wired = 0; m_phase = 0; m_op = 0; m_idx_lat = 0; m_rnd_lat = 31;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd0:    return m_index;
            5'd1:    return EN ? 32'(m_random) : 32'd0;
            5'd2:    return m_lo0;
            5'd3:    return m_lo1;
            5'd5:    return m_pm;
            5'd6:    return EN ? 32'(m_wired) : 32'd0;
            5'd10:   return m_hi;
            default: return 32'd0;
        endcase
    endfunction

    // Random walks down from 31 to its floor, then wraps; floor is 0 with no wired entries.
    function automatic int rnd_next(input int r, input int w);
        int floor_v;
        if (w >= 31) return 31;
        floor_v = (w == 0) ? 0 : w + 1;
        return (r == floor_v) ? 31 : r - 1;
    endfunction

    task automatic model_check();
        int exp_idx;
        if (m_phase == 1) exp_idx = (m_op == 2 && EN) ? m_rnd_lat : m_idx_lat;
        else              exp_idx = int'(m_index[4:0]);
        chk("op_ready",     32'(op_ready), 32'(m_phase == 0));
        chk("op_done",      32'(op_done),  32'(m_phase == 2));
        chk("tlb_we",       32'(tlb_we),   32'(m_phase == 1 && (m_op == 1 || m_op == 2)));
        chk("tlb_index",    32'(tlb_index), 32'(exp_idx));
        chk("tlb_entryhi",  tlb_entryhi,  m_hi);
        chk("tlb_entrylo0", tlb_entrylo0, m_lo0);
        chk("tlb_entrylo1", tlb_entrylo1, m_lo1);
        chk("tlb_mask",     32'(tlb_mask), m_pm >> 13);
        chk("mfc0_data",    mfc0_data,    m_read(cp0_addr));
    endtask

    // Called at a falling edge with inputs already driven for this cycle.
    task automatic step();
        logic [31:0] n_index, n_lo0, n_lo1, n_pm, n_hi;
        int n_random, n_wired, n_phase, n_op, n_idx_lat, n_rnd_lat;
        #1;
        model_check();
        n_index = m_index; n_lo0 = m_lo0; n_lo1 = m_lo1; n_pm = m_pm; n_hi = m_hi;
        n_random = m_random; n_wired = m_wired; n_phase = m_phase;
        n_op = m_op; n_idx_lat = m_idx_lat; n_rnd_lat = m_rnd_lat;
        if (!rst) begin
            if (mtc0_we) begin
                case (cp0_addr)
                    5'd0:  n_index = (m_index & 32'h8000_0000) | (mtc0_data & 32'h1F);
                    5'd2:  n_lo0 = mtc0_data & 32'h03FF_FFFF;
                    5'd3:  n_lo1 = mtc0_data & 32'h03FF_FFFF;
                    5'd5:  n_pm = mtc0_data & 32'h01FF_E000;
                    5'd6:  if (EN) n_wired = int'(mtc0_data & 32'h1F);
                    5'd10: n_hi = mtc0_data & 32'hFFFF_E0FF;
                    default: ;
                endcase
            end
            if (exc_tlb) n_hi = {exc_badvpn2, 13'h0} | (m_hi & 32'hFF);
            if (m_phase == 1 && m_op == 0) begin
                n_hi  = tlb_entryhi_rd & 32'hFFFF_E0FF;
                n_lo0 = tlb_entrylo0_rd & 32'h03FF_FFFF;
                n_lo1 = tlb_entrylo1_rd & 32'h03FF_FFFF;
                n_pm  = 32'(tlb_mask_rd) << 13;
            end
            if (m_phase == 1 && m_op == 3) n_index = tlb_probe_idx & 32'h8000_001F;
            if (mtc0_we && cp0_addr == 5'd6) n_random = 31;
            else                             n_random = rnd_next(m_random, m_wired);
            if (m_phase == 0 && op_valid) begin
                n_phase = 1; n_op = int'(op);
                n_idx_lat = int'(m_index[4:0]); n_rnd_lat = m_random;
            end else if (m_phase == 1) n_phase = 2;
            else if (m_phase == 2)     n_phase = 0;
        end
        @(posedge clk);
        if (rst) model_reset();
        else begin
            m_index = n_index; m_lo0 = n_lo0; m_lo1 = n_lo1; m_pm = n_pm; m_hi = n_hi;
            m_random = n_random; m_wired = n_wired; m_phase = n_phase;
            m_op = n_op; m_idx_lat = n_idx_lat; m_rnd_lat = n_rnd_lat;
        end
        @(negedge clk);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        mtc0_we = 1'b1; cp0_addr = a; mtc0_data = d;
        step();
        mtc0_we = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] o);
        op_valid = 1'b1; op = o;
        step();
        op_valid = 1'b0;
        step();
        step();
    endtask

    initial begin
        int exp_idx;
        rst = 1'b1; op_valid = 0; op = 0; mtc0_we = 0; cp0_addr = 0; mtc0_data = 0;
        exc_tlb = 0; exc_badvpn2 = 0; tlb_mask_rd = 0; tlb_entryhi_rd = 0;
        tlb_entrylo0_rd = 0; tlb_entrylo1_rd = 0; tlb_probe_idx = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;

        // Reset state
        cp0_addr = 5'd1; #1;
        chk("rst_random", mfc0_data, EN ? 32'd31 : 32'd0);
        chk("rst_ready", 32'(op_ready), 32'd1);
        chk("rst_index_out", 32'(tlb_index), 32'd0);
        cp0_addr = 5'd0; #1;
        chk("rst_index", mfc0_data, 32'd0);
        step();

        // TLBWI
        mtc0(5'd0, 32'd3);
        mtc0(5'd10, 32'h0040_2005);
        mtc0(5'd2, 32'h41F);
        mtc0(5'd3, 32'h45F);
        mtc0(5'd5, 32'h0);
        op_valid = 1'b1; op = 2'b01;
        step();
        op_valid = 1'b0; #1;
        chk("wi_we", 32'(tlb_we), 32'd1);
        chk("wi_index", 32'(tlb_index), 32'd3);
        chk("wi_entryhi", tlb_entryhi, 32'h0040_2005);
        chk("wi_lo1", tlb_entrylo1, 32'h45F);
        step(); #1;
        chk("wi_done", 32'(op_done), 32'd1);
        chk("wi_we_off", 32'(tlb_we), 32'd0);
        step(); #1;
        chk("wi_ready", 32'(op_ready), 32'd1);

        // TLBP hit then miss
        tlb_probe_idx = 32'h0000_0003;
        run_op(2'b11);
        cp0_addr = 5'd0; #1;
        chk("tlbp_hit", mfc0_data, 32'h0000_0003);
        tlb_probe_idx = 32'h8000_0000;
        run_op(2'b11);
        cp0_addr = 5'd0; #1;
        chk("tlbp_miss", mfc0_data, 32'h8000_0000);

        // TLBR
        mtc0(5'd0, 32'd7);
        tlb_entryhi_rd = 32'h2000_0000; tlb_entrylo0_rd = 32'h42;
        tlb_entrylo1_rd = 32'h83; tlb_mask_rd = 12'h003;
        op_valid = 1'b1; op = 2'b00;
        step();
        op_valid = 1'b0; #1;
        chk("tlbr_index", 32'(tlb_index), 32'd7);
        step(); step();
        cp0_addr = 5'd10; #1; chk("tlbr_hi", mfc0_data, 32'h2000_0000);
        cp0_addr = 5'd2;  #1; chk("tlbr_lo0", mfc0_data, 32'h42);
        cp0_addr = 5'd3;  #1; chk("tlbr_lo1", mfc0_data, 32'h83);
        cp0_addr = 5'd5;  #1; chk("tlbr_pm", mfc0_data, 32'h6000);

        // Wired = 4: Random sweeps 31..5 then wraps
        mtc0(5'd6, 32'd4);
        cp0_addr = 5'd1;
        for (int k = 0; k < 28; k++) begin
            #1;
            if (EN) chk("random_seq", mfc0_data, (k < 27) ? 32'(31 - k) : 32'd31);
            else    chk("random_absent", mfc0_data, 32'd0);
            step();
        end
        op_valid = 1'b1; op = 2'b10;
        exp_idx = EN ? m_random : int'(m_index[4:0]);
        step();
        op_valid = 1'b0; #1;
        chk("tlbwr_index", 32'(tlb_index), 32'(exp_idx));
        chk("tlbwr_we", 32'(tlb_we), 32'd1);
        if (EN) chk("tlbwr_ge_wired", 32'(tlb_index >= 5'd4), 32'd1);
        step(); step();

        // exc_tlb beats a same-cycle mtc0 EntryHi, ASID kept
        mtc0(5'd10, 32'h0000_00FF);
        exc_tlb = 1'b1; exc_badvpn2 = 19'h12345;
        mtc0(5'd10, 32'hFFFF_E0FF);
        exc_tlb = 1'b0;
        cp0_addr = 5'd10; #1;
        chk("exc_hi", mfc0_data, 32'h2468_A0FF);

        // Reset mid-operation
        op_valid = 1'b1; op = 2'b01;
        step();
        op_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; #1;
        chk("abort_done", 32'(op_done), 32'd0);
        chk("abort_ready", 32'(op_ready), 32'd1);
        step(); #1;
        chk("abort_done2", 32'(op_done), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            logic [4:0] addrs [8];
            addrs = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd6, 5'd10, 5'($urandom)};
            rst             = ($urandom_range(0, 299) == 0);
            op_valid        = ($urandom_range(0, 2) == 0);
            op              = 2'($urandom);
            mtc0_we         = ($urandom_range(0, 2) == 0);
            cp0_addr        = addrs[$urandom_range(0, 7)];
            mtc0_data       = $urandom;
            exc_tlb         = ($urandom_range(0, 7) == 0);
            exc_badvpn2     = 19'($urandom);
            tlb_probe_idx   = $urandom;
            tlb_entryhi_rd  = $urandom;
            tlb_entrylo0_rd = $urandom;
            tlb_entrylo1_rd = $urandom;
            tlb_mask_rd     = 12'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
